imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Byte-serial program loader that writes the instruction memory, the write-side counterpart of the read-only instruction fetch port. It accepts a framed byte stream from a host link (e.g. UART RX), assembles little-endian 32-bit words and issues word writes to the memory's write port. While a load is in progress it holds the core in reset.

Parameters:
ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words (256).
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that arms the loader
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
mem_we  output  1  one-cycle word write strobe
mem_addr  output  ADDR_W  word address (byte address = mem_addr<<2)
mem_wdata  output  32  word to write
busy  output  1  frame in progress
done  output  1  sticky: last frame loaded successfully
error  output  1  sticky: last frame rejected
cpu_hold  output  1  keep core in reset; equals busy

Behaviour:
- One clock domain (clk). rst_n is asynchronous and active-low. Reset: state IDLE; in_ready, mem_we, busy, done, error and cpu_hold = 0; mem_addr, mem_wdata, counters = 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes (LSB first per word), then optional checksum.
- Byte transfer happens only in cycles where in_valid && in_ready. in_ready is 1 in SYNC, LEN0, LEN1, DATA and CSUM; 0 in IDLE, DONE and ERROR.
- State transitions:
  - IDLE, DONE or ERROR: start moves to SYNC and clears done, error, mem_addr and the byte counter.
  - start while busy is ignored.
- SYNC: a byte equal to SYNC_BYTE moves to LEN0. Any other byte is discarded and the state stays SYNC.
- LEN0: latch the low length byte. LEN1: latch the high length byte.
  - N == 0: go to DONE (or to CSUM when the feature is on).
  - N > 2**ADDR_W: go to ERROR.
  - Otherwise go to DATA.
- DATA: shift each byte into a 32-bit assembly register at lane byte_cnt[1:0].
  - On acceptance of the 4th byte, the next cycle has mem_we = 1 with mem_wdata = the assembled word and mem_addr = the current word index. Write latency is 1 cycle after the last byte.
  - The word index increments after the write. It never wraps: the length check guarantees index < 2**ADDR_W.
  - After word N-1 is accepted, go to DONE (or to CSUM).
- DONE: done = 1, busy = 0. ERROR: error = 1, busy = 0.
- busy = 1 in SYNC through CSUM; cpu_hold follows busy.
- A byte arriving in the same cycle as the final mem_we is handled normally: the write happens, and the byte is accepted only if the next state is still receiving.
- Deasserting rst_n mid-frame aborts immediately. Partially written memory contents are left as they are.

Optional Feature:
IMEM_LOADER_CSUM_EN:
- Defined: after the data bytes, the state goes to CSUM and expects one byte equal to the XOR of all LEN and data bytes.
  - Match: go to DONE.
  - Mismatch: go to ERROR. Words already written stay in memory, but done stays 0 and the core must not be released by software.
- Undefined: no CSUM state; DATA goes straight to DONE.

Decomposition:
- Shared package imem_pkg: state enum (IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERROR), SYNC_BYTE default, IMEM_ADDR_W = 8, WORD_BYTES = 4.
- One sub-module, imem_word_packer: byte-lane shift register plus 2-bit lane counter; emits word_valid and word. The FSM, length and address counters stay in imem_loader.

Test Plan:
- start; bytes A5 02 00 93 00 A0 00 13 01 40 01 -> writes addr0 = 00A00093, addr1 = 01400113; mem_we high exactly 2 cycles; done = 1, busy/cpu_hold = 0.
- start; bytes 00 FF A5 01 00 78 56 34 12 -> the 00 and FF are discarded; single write addr0 = 12345678; done = 1.
- start; A5 01 01 (N = 257) -> error = 1, no mem_we, in_ready = 0 afterwards; a new start clears error.
- Gaps of 0–5 idle cycles between bytes (in_valid low), plus a second start pulse mid-frame -> identical writes to the back-to-back case; the mid-frame start has no effect.
- rst_n asserted after 6 data bytes -> all outputs 0 asynchronously; after release and a fresh start, a full frame loads correctly from addr0.
- With IMEM_LOADER_CSUM_EN: A5 01 00 78 56 34 12 plus checksum 0x09 -> done. The same frame with checksum 0x00 -> error = 1, done = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM state encoding, default sync marker and word geometry.
package imem_pkg;

    localparam int         IMEM_ADDR_W   = 8;
    localparam int         WORD_BYTES    = 4;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } imem_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler for the program loader.
// Ports: clr_i restarts lane 0, push_i/byte_i feed one byte, lane_o is the
// next lane, word_valid_o pulses one cycle after the 4th byte with word_o.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [31:0] sr_q, sr_d;
    logic [1:0]  lane_q, lane_d;
    logic        vld_q, vld_d;

    // Shifting right places the first byte in bits [7:0] after four pushes.
    always_comb begin
        sr_d   = sr_q;
        lane_d = lane_q;
        vld_d  = 1'b0;
        if (clr_i) begin
            sr_d   = '0;
            lane_d = '0;
        end else if (push_i) begin
            sr_d   = {byte_i, sr_q[31:8]};
            lane_d = lane_q + 2'd1;
            vld_d  = (lane_q == 2'(WORD_BYTES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            lane_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            lane_q <= lane_d;
            vld_q  <= vld_d;
        end
    end

    assign lane_o       = lane_q;
    assign word_valid_o = vld_q;
    assign word_o       = sr_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: SYNC, LEN_LO, LEN_HI, 4*N data bytes.
// Ports: start arms, in_valid/in_ready/in_data stream, mem_we/mem_addr/
// mem_wdata write port, busy/cpu_hold during a frame, sticky done/error.
// Build option IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int         ADDR_W    = IMEM_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam int          RW    = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef IMEM_LOADER_CSUM_EN
    localparam imem_state_e FIN = CSUM;
`else
    localparam imem_state_e FIN = DONE;
`endif

    imem_state_e       state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;

    logic        accept;
    logic        pk_clr;
    logic        pk_push;
    logic [1:0]  pk_lane;
    logic        pk_vld;
    logic [31:0] pk_word;
    logic [15:0] n;

    assign accept = in_valid && in_ready;
    assign n      = {in_data, len_lo_q};

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (pk_clr),
        .push_i       (pk_push),
        .byte_i       (in_data),
        .lane_o       (pk_lane),
        .word_valid_o (pk_vld),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        csum_d   = csum_q;
        in_ready = 1'b0;
        pk_clr   = 1'b0;
        pk_push  = 1'b0;

        // Saturate so a full-depth frame leaves the index on the last word.
        if (pk_vld && (addr_q != '1)) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = SYNC;
                    addr_d  = '0;
                    rem_d   = '0;
                    csum_d  = '0;
                    pk_clr  = 1'b1;
                end
            end
            SYNC: begin
                in_ready = 1'b1;
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = LEN0;
                end
            end
            LEN0: begin
                in_ready = 1'b1;
                if (accept) begin
                    len_lo_d = in_data;
                    csum_d   = csum_q ^ in_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                in_ready = 1'b1;
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (n == 16'd0) begin
                        state_d = FIN;
                    end else if (32'(n) > DEPTH) begin
                        state_d = ERROR;
                    end else begin
                        rem_d   = n[RW-1:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (accept) begin
                    pk_push = 1'b1;
                    csum_d  = csum_q ^ in_data;
                    if (pk_lane == 2'(WORD_BYTES - 1)) begin
                        rem_d = rem_q - RW'(1);
                        if (rem_q == RW'(1)) begin
                            state_d = FIN;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_lo_q <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            csum_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            csum_q   <= csum_d;
        end
    end

    assign busy      = state_q inside {SYNC, LEN0, LEN1, DATA, CSUM};
    assign cpu_hold  = busy;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign mem_we    = pk_vld;
    assign mem_addr  = addr_q;
    assign mem_wdata = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected word writes.
// Frames are driven byte by byte; writes are popped and compared as they occur.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    int gap_max  = 0;
    logic [7:0] xs;
    logic [39:0] exp_q[$];

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            logic [39:0] e;
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {24'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", {24'd0, mem_addr}, {24'd0, e[39:32]});
                chk("wdata", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        int guard;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int i = 0; i < g; i++) step();
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                step();
                break;
            end
            step();
            guard++;
            if (guard > 40) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        xs = n[7:0] ^ n[15:8];
    endtask

    task automatic send_word(input logic [7:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b  = w[8*i +: 8];
            xs = xs ^ b;
            send_byte(b);
        end
    endtask

    task automatic end_frame();
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(xs);
`endif
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            step();
            guard++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        step();
        step();
    endtask

    task automatic frame_a();
        send_hdr(16'd2);
        send_word(8'd0, 32'h00A0_0093);
        send_word(8'd1, 32'h0140_0113);
        end_frame();
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_outs", {26'd0, mem_we, busy, done, error, cpu_hold, 1'b0},
            32'd0);
        chk("rst_addr_data", mem_wdata | {24'd0, mem_addr}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Back-to-back two-word frame
        we_cnt = 0;
        pulse_start();
        chk("busy_after_start", {30'd0, busy, cpu_hold}, 32'd3);
        frame_a();
        wait_idle();
        chk("a_we_cnt", we_cnt, 2);
        chk("a_done", {29'd0, done, busy, cpu_hold}, 32'd4);
        chk("a_ready_low", {31'd0, in_ready}, 32'd0);

        // Garbage before sync is discarded
        we_cnt = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_hdr(16'd1);
        send_word(8'd0, 32'h1234_5678);
        end_frame();
        wait_idle();
        chk("b_we_cnt", we_cnt, 1);
        chk("b_done", {30'd0, done, error}, 32'd2);

        // Oversize length rejected
        we_cnt = 0;
        pulse_start();
        send_hdr(16'd257);
        wait_idle();
        chk("c_error", {30'd0, done, error}, 32'd1);
        chk("c_ready_low", {31'd0, in_ready}, 32'd0);
        chk("c_no_we", we_cnt, 0);
        pulse_start();
        chk("c_error_cleared", {30'd0, error, busy}, 32'd1);

        // Idle gaps plus a stray start pulse mid-frame
        we_cnt  = 0;
        gap_max = 5;
        send_hdr(16'd2);
        exp_q.push_back({8'd0, 32'h00A0_0093});
        send_byte(8'h93);
        send_byte(8'h00);
        pulse_start();
        send_byte(8'hA0);
        send_byte(8'h00);
        xs = xs ^ 8'h93 ^ 8'hA0;
        send_word(8'd1, 32'h0140_0113);
        end_frame();
        gap_max = 0;
        wait_idle();
        chk("d_we_cnt", we_cnt, 2);
        chk("d_done", {30'd0, done, error}, 32'd2);

        // Zero-length frame
        we_cnt = 0;
        pulse_start();
        send_hdr(16'd0);
        end_frame();
        wait_idle();
        chk("e_zero_len", {30'd0, done, error}, 32'd2);
        chk("e_no_we", we_cnt, 0);

        // Full-depth frame of 256 words
        we_cnt = 0;
        pulse_start();
        send_hdr(16'd256);
        for (int i = 0; i < 256; i++) send_word(8'(i), $urandom);
        end_frame();
        wait_idle();
        chk("f_we_cnt", we_cnt, 256);
        chk("f_done", {30'd0, done, error}, 32'd2);

        // Asynchronous reset mid-frame, then a clean reload
        we_cnt = 0;
        pulse_start();
        send_hdr(16'd2);
        send_word(8'd0, 32'hCAFE_F00D);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("g_rst_ctrl", {27'd0, in_ready, mem_we, busy, done, cpu_hold},
            32'd0);
        chk("g_rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("g_rst_wdata", mem_wdata, 32'd0);
        chk("g_rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pulse_start();
        send_hdr(16'd1);
        send_word(8'd0, 32'h1234_5678);
        end_frame();
        wait_idle();
        chk("g_we_cnt", we_cnt, 2);
        chk("g_done", {30'd0, done, error}, 32'd2);

`ifdef IMEM_LOADER_CSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_hdr(16'd1);
        send_word(8'd0, 32'h1234_5678);
        chk("h_csum_value", {24'd0, xs}, 32'h09);
        send_byte(8'h09);
        wait_idle();
        chk("h_csum_ok", {30'd0, done, error}, 32'd2);
        pulse_start();
        send_hdr(16'd1);
        send_word(8'd0, 32'h1234_5678);
        send_byte(8'h00);
        wait_idle();
        chk("h_csum_bad", {30'd0, done, error}, 32'd1);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
